// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - states, opcodes and control encodings for the multi-cycle MIPS controller
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       memto_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Anything not recognised here lands in TRAP.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_R_TYPE:   return S_EXEC;
      OP_LW, OP_SW: return S_MEM_ADDR;
      OP_BEQ:      return S_BRANCH;
      OP_J:        return S_JUMP;
      default:     return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - datapath-facing signals of the multi-cycle controller
interface multicycle_controller_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             reg_dst;
  logic             memto_reg;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic             illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_retired, retired_count, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           reg_dst, memto_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_retired, retired_count, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// rtl/multicycle_ctrl_decode.sv - combinational state to datapath-control decode
module multicycle_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl,
  output logic   instr_retired
);

  always_comb begin
    ctrl          = '0;
    instr_retired = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
        instr_retired  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
        instr_retired  = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        instr_retired  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        instr_retired      = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_JUMP;
        instr_retired  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS sequencer: state, latched opcode, retire counter, trap flag
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t           state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             illegal_q, illegal_d;
  ctrl_t            ctrl;
  logic             retired;

  multicycle_ctrl_decode u_decode (
    .state         (state_q),
    .mem_ready     (bus.mem_ready),
    .ctrl          (ctrl),
    .instr_retired (retired)
  );

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    count_d   = count_q + {{(CNT_W-1){1'b0}}, retired};
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = bus.opcode;
        state_d  = decode_next(bus.opcode);
        if (decode_next(bus.opcode) == S_TRAP) illegal_d = 1'b1;
      end
      // Only lw and sw reach MEM_ADDR, so sw is the sole opcode to single out.
      S_MEM_ADDR: state_d = (opcode_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      opcode_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.memto_reg     = ctrl.memto_reg;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.alu_op        = ctrl.alu_op;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_retired = retired;
  assign bus.retired_count = count_q;
  assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(16)) bus ();
  multicycle_controller_if #(.CNT_W(3))  bus_s ();

  multicycle_controller #(.CNT_W(16)) dut   (.clk(clk), .reset(reset), .bus(bus));
  multicycle_controller #(.CNT_W(3))  dut_s (.clk(clk), .reset(reset), .bus(bus_s));

  assign bus_s.opcode    = bus.opcode;
  assign bus_s.zero      = bus.zero;
  assign bus_s.mem_ready = bus.mem_ready;

  typedef struct {
    string       tag;
    state_t      st;
    logic [16:0] ctl;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ret_q[$];
  logic [15:0] issue_cnt;
  logic        pending;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Field order: pc_write pc_write_cond i_or_d mem_read mem_write ir_write
  // reg_dst memto_reg reg_write alu_src_a alu_src_b alu_op pc_source instr_retired
  function automatic logic [16:0] exp_vec(input state_t st, input logic mr);
    logic pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, ret;
    logic [1:0] sb_, op, ps;
    {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, ret} = '0;
    sb_ = 2'b00; op = 2'b00; ps = 2'b00;
    case (st)
      S_FETCH:    begin mrd = 1; irw = mr; pw = mr; sb_ = 2'b01; op = 2'b11; end
      S_DECODE:   begin sb_ = 2'b11; op = 2'b11; end
      S_MEM_ADDR: begin sa = 1; sb_ = 2'b10; op = 2'b11; end
      S_MEM_RD:   begin mrd = 1; iod = 1; end
      S_MEM_WB:   begin rw = 1; m2r = 1; ret = 1; end
      S_MEM_WR:   begin mwr = 1; iod = 1; ret = mr; end
      S_EXEC:     begin sa = 1; end
      S_R_WB:     begin rw = 1; rdst = 1; ret = 1; end
      S_BRANCH:   begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; ret = 1; end
      S_JUMP:     begin pw = 1; ps = 2'b10; ret = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb_, op, ps, ret};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.reg_dst, bus.memto_reg, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source, bus.instr_retired};
  endfunction

  // One clock cycle: drive inputs, push the expectation, compare at the falling edge.
  task automatic cyc(input string tag, input state_t st, input logic mr,
                     input logic [5:0] op, input logic rst);
    exp_t       e;
    logic [15:0] exp_c;
    bus.mem_ready = mr;
    bus.opcode    = op;
    bus.zero      = 1'($urandom_range(0, 1));
    reset         = rst;
    e.tag = tag; e.st = st; e.ctl = exp_vec(st, mr); e.ill = (st == S_TRAP);
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, "_state"}, 32'(dut.state_q), 32'(e.st));
    chk({e.tag, "_ctl"}, 32'(obs_vec()), 32'(e.ctl));
    chk({e.tag, "_ill"}, 32'(bus.illegal_op), 32'(e.ill));
    if (e.st == S_IDLE) chk({e.tag, "_cnt0"}, 32'(bus.retired_count), 32'd0);
    if (e.ctl[0] && !rst) pending = 1'b1;
    @(posedge clk);
    #1;
    if (rst) begin
      ret_q.delete();
      issue_cnt = '0;
      pending   = 1'b0;
    end else if (pending) begin
      pending = 1'b0;
      exp_c   = ret_q.pop_front();
      chk({e.tag, "_count"}, 32'(bus.retired_count), 32'(exp_c));
      chk({e.tag, "_count_small"}, 32'(bus_s.retired_count), 32'(exp_c[2:0]));
    end
  endtask

  task automatic issue();
    issue_cnt = issue_cnt + 16'd1;
    ret_q.push_back(issue_cnt);
  endtask

  task automatic fetch(input string tag, input int waits);
    for (int i = 0; i < waits; i++) cyc({tag, "_fetch_wait"}, S_FETCH, 1'b0, 6'h3f, 1'b0);
    cyc({tag, "_fetch"}, S_FETCH, 1'b1, 6'h3f, 1'b0);
  endtask

  task automatic run_r(input string tag, input int fw);
    issue();
    fetch(tag, fw);
    cyc({tag, "_decode"}, S_DECODE, 1'b0, OP_R_TYPE, 1'b0);
    cyc({tag, "_exec"},   S_EXEC,   1'b1, 6'h3f, 1'b0);
    cyc({tag, "_wb"},     S_R_WB,   1'b1, 6'h3f, 1'b0);
  endtask

  task automatic run_lw(input string tag, input int waits);
    issue();
    fetch(tag, 0);
    cyc({tag, "_decode"}, S_DECODE,   1'b1, OP_LW, 1'b0);
    cyc({tag, "_addr"},   S_MEM_ADDR, 1'b1, OP_SW, 1'b0);
    for (int i = 0; i < waits; i++) cyc({tag, "_rd_wait"}, S_MEM_RD, 1'b0, 6'h3f, 1'b0);
    cyc({tag, "_rd"}, S_MEM_RD, 1'b1, 6'h3f, 1'b0);
    cyc({tag, "_wb"}, S_MEM_WB, 1'b1, 6'h3f, 1'b0);
  endtask

  task automatic run_sw(input string tag, input int waits);
    issue();
    fetch(tag, 0);
    cyc({tag, "_decode"}, S_DECODE,   1'b1, OP_SW, 1'b0);
    cyc({tag, "_addr"},   S_MEM_ADDR, 1'b1, OP_LW, 1'b0);
    for (int i = 0; i < waits; i++) cyc({tag, "_wr_wait"}, S_MEM_WR, 1'b0, 6'h3f, 1'b0);
    cyc({tag, "_wr"}, S_MEM_WR, 1'b1, 6'h3f, 1'b0);
  endtask

  task automatic run_beq(input string tag);
    issue();
    fetch(tag, 0);
    cyc({tag, "_decode"}, S_DECODE, 1'b1, OP_BEQ, 1'b0);
    cyc({tag, "_branch"}, S_BRANCH, 1'b1, 6'h3f, 1'b0);
  endtask

  task automatic run_j(input string tag, input int fw);
    issue();
    fetch(tag, fw);
    cyc({tag, "_decode"}, S_DECODE, 1'b1, OP_J, 1'b0);
    cyc({tag, "_jump"},   S_JUMP,   1'b0, 6'h3f, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; pending = 1'b0; issue_cnt = '0;
    reset = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 6'h3f; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    cyc("reset_idle", S_IDLE, 1'b1, 6'h3f, 1'b0);
    run_r("r0", 0);
    run_lw("lw0", 2);
    run_sw("sw0", 1);
    run_beq("beq0");
    run_j("j0", 0);
    run_r("r1", 1);
    run_j("j1", 2);
    run_beq("beq1");
    run_sw("sw1", 0);

    fetch("trap", 0);
    cyc("trap_decode", S_DECODE, 1'b1, 6'h3f, 1'b0);
    for (int i = 0; i < 22; i++) cyc("trap_hold", S_TRAP, 1'(i % 2), 6'h3f, 1'b0);
    cyc("trap_reset", S_TRAP, 1'b1, 6'h3f, 1'b1);
    cyc("trap_idle", S_IDLE, 1'b1, 6'h3f, 1'b0);
    run_r("r2", 0);

    issue();
    fetch("lwrst", 0);
    cyc("lwrst_decode", S_DECODE,   1'b1, OP_LW, 1'b0);
    cyc("lwrst_addr",   S_MEM_ADDR, 1'b1, 6'h3f, 1'b0);
    cyc("lwrst_wait",   S_MEM_RD,   1'b0, 6'h3f, 1'b0);
    cyc("lwrst_reset",  S_MEM_RD,   1'b1, 6'h3f, 1'b1);
    cyc("lwrst_idle",   S_IDLE,     1'b1, 6'h3f, 1'b0);
    run_j("j2", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
